// File: rtl/pc_file_pkg.sv
// pc_file_pkg: shared types and constants for the multi-hart PC file.
//   hart_state_t     : per-hart run/halt state
//   PC_INC           : fetch advance per issue, in bytes
//   DEFAULT_RESET_PC : PC of hart 0 after reset
//   DEFAULT_TRAP_PC  : PC loaded on a trap or misaligned redirect
//   hart_id_w()      : hart-id width for a given hart count (at least 1)
package pc_file_pkg;

    typedef enum logic {
        HALTED = 1'b0,
        RUN    = 1'b1
    } hart_state_t;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0040_0100;

    function automatic int hart_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_file_if.sv
// pc_file_if: control/issue bundle between the fetch-control side and pc_file.
//   hold, hart_stall             : global stall and per-hart stall
//   redirect_valid/_hart/_pc     : branch/jump target for one hart
//   trap_valid/_hart             : force one hart to the trap vector
//   start_valid/_hart/_pc        : start a halted hart
//   issue_valid/_hart/_pc        : hart selected this cycle and its fetch PC
//   misalign                     : one-cycle pulse, misaligned redirect became a trap
// Modports: master = fetch-control side, slave = pc_file.
interface pc_file_if
    import pc_file_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int HARTS = 4
);
    localparam int HW = hart_id_w(HARTS);

    logic             hold;
    logic [HARTS-1:0] hart_stall;
    logic             redirect_valid;
    logic [HW-1:0]    redirect_hart;
    logic [WIDTH-1:0] redirect_pc;
    logic             trap_valid;
    logic [HW-1:0]    trap_hart;
    logic             start_valid;
    logic [HW-1:0]    start_hart;
    logic [WIDTH-1:0] start_pc;
    logic             issue_valid;
    logic [HW-1:0]    issue_hart;
    logic [WIDTH-1:0] issue_pc;
    logic             misalign;

    modport master (
        output hold, hart_stall,
        output redirect_valid, redirect_hart, redirect_pc,
        output trap_valid, trap_hart,
        output start_valid, start_hart, start_pc,
        input  issue_valid, issue_hart, issue_pc, misalign
    );

    modport slave (
        input  hold, hart_stall,
        input  redirect_valid, redirect_hart, redirect_pc,
        input  trap_valid, trap_hart,
        input  start_valid, start_hart, start_pc,
        output issue_valid, issue_hart, issue_pc, misalign
    );

endinterface

// File: rtl/pc_file_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one eligible hart.
//   eligible    : per-hart eligibility vector
//   rr          : hart id with highest priority this cycle
//   grant       : first eligible hart scanning rr, rr+1, ... modulo HARTS
//   grant_valid : at least one hart is eligible
module rr_arbiter
#(
    parameter  int HARTS = 4,
    localparam int HW    = pc_file_pkg::hart_id_w(HARTS)
) (
    input  logic [HARTS-1:0] eligible,
    input  logic [HW-1:0]    rr,
    output logic [HW-1:0]    grant,
    output logic             grant_valid
);

    logic [HW:0]   sum;
    logic [HW-1:0] idx;

    // Scan from the farthest offset down to rr so the closest eligible
    // hart is the last one written and therefore wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = HARTS - 1; i >= 0; i--) begin
            sum = {1'b0, rr} + (HW + 1)'(i);
            if (sum >= (HW + 1)'(HARTS)) begin
                sum = sum - (HW + 1)'(HARTS);
            end
            idx = sum[HW-1:0];
            if (eligible[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_file.sv
// pc_file: per-hart program counters and run/halt state for the
// barrel-threaded fetch stage. Each cycle one eligible hart is issued
// round-robin and its PC advanced by PC_INC; traps, redirects and starts
// update individual harts with priority trap > redirect > start > issue.
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-high reset
//   bus   : pc_file_if slave (stalls, redirect/trap/start, issue outputs)
module pc_file
    import pc_file_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               HARTS    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] TRAP_PC  = WIDTH'(DEFAULT_TRAP_PC)
) (
    input  logic     clk,
    input  logic     reset,
    pc_file_if.slave bus
);

    localparam int HW = hart_id_w(HARTS);

    logic [WIDTH-1:0] pc_q [HARTS];
    hart_state_t      state_q [HARTS];
    logic [HW-1:0]    rr_q;
    logic             misalign_q;

    logic [HARTS-1:0] eligible;
    logic [HARTS-1:0] trap_hit;
    logic [HARTS-1:0] redir_hit;
    logic [HARTS-1:0] start_hit;
    logic             redir_aligned;
    logic             misalign_nxt;
    logic [HW-1:0]    sel;
    logic             sel_valid;
    logic             issue_valid;
    logic [HW-1:0]    rr_nxt;

    assign redir_aligned = (bus.redirect_pc[1:0] == 2'b00);

    // Hart ids are matched against each existing hart only, so an id beyond
    // HARTS-1 simply hits nothing. A redirect loses to a trap on the same
    // hart, and then it cannot raise misalign either.
    always_comb begin
        eligible     = '0;
        trap_hit     = '0;
        redir_hit    = '0;
        start_hit    = '0;
        misalign_nxt = 1'b0;
        for (int h = 0; h < HARTS; h++) begin
            eligible[h]  = (state_q[h] == RUN) && !bus.hart_stall[h];
            trap_hit[h]  = bus.trap_valid && (bus.trap_hart == HW'(h))
                           && (state_q[h] == RUN);
            redir_hit[h] = bus.redirect_valid && (bus.redirect_hart == HW'(h))
                           && (state_q[h] == RUN) && !trap_hit[h];
            start_hit[h] = bus.start_valid && (bus.start_hart == HW'(h))
                           && (state_q[h] == HALTED);
            if (redir_hit[h] && !redir_aligned) begin
                misalign_nxt = 1'b1;
            end
        end
    end

    rr_arbiter #(.HARTS(HARTS)) u_rr_arbiter (
        .eligible    (eligible),
        .rr          (rr_q),
        .grant       (sel),
        .grant_valid (sel_valid)
    );

    assign issue_valid = !bus.hold && sel_valid;
    assign rr_nxt      = (sel == HW'(HARTS - 1)) ? '0 : sel + HW'(1);

    assign bus.issue_valid = issue_valid;
    assign bus.issue_hart  = issue_valid ? sel : '0;
    assign bus.issue_pc    = issue_valid ? pc_q[sel] : '0;
    assign bus.misalign    = misalign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int h = 0; h < HARTS; h++) begin
                pc_q[h]    <= (h == 0) ? RESET_PC : '0;
                state_q[h] <= (h == 0) ? RUN : HALTED;
            end
            rr_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_nxt;
            if (issue_valid) begin
                rr_q <= rr_nxt;
            end
            for (int h = 0; h < HARTS; h++) begin
                if (trap_hit[h]) begin
                    pc_q[h] <= TRAP_PC;
                end else if (redir_hit[h]) begin
                    pc_q[h] <= redir_aligned ? bus.redirect_pc : TRAP_PC;
                end else if (start_hit[h]) begin
                    pc_q[h]    <= bus.start_pc;
                    state_q[h] <= RUN;
                end else if (issue_valid && (sel == HW'(h))) begin
                    pc_q[h] <= pc_q[h] + WIDTH'(PC_INC);
                end
            end
        end
    end

endmodule
